mem_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares the single-port data memory (DataMEM) between Ncores processor cores.
- Each core raises a load or write request with address/data and holds it; the arbiter issues one memory operation at a time and returns read data with a one-cycle acknowledge.
- Sits between the core load/store units and the memory's dataIN/dataADDR/dataLoad/dataWrite/dataOUT port.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/rr_picker.sv | 32 +++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the DataMEM round-robin arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} arbStateT;

   typedef enum logic {CMD_LOAD, CMD_WRITE} arbCmdT;

   localparam int unsigned DefTAM  = 16;
   localparam int unsigned DefLmem = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side and memory-side bus of the DataMEM arbiter.
// With MEM_ARB_LOCK_EN defined the bus also carries the per-core coreLock request.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int unsigned Ncores = 2,
   parameter int unsigned TAM    = DefTAM
);

   logic [Ncores-1:0]     coreLoad;
   logic [Ncores-1:0]     coreWrite;
   logic [Ncores*TAM-1:0] coreADDR;
   logic [Ncores*TAM-1:0] coreIN;
   logic [Ncores*TAM-1:0] coreOUT;
   logic [Ncores-1:0]     coreAck;
   logic [TAM-1:0]        memADDR;
   logic [TAM-1:0]        memIN;
   logic                  memLoad;
   logic                  memWrite;
   logic [TAM-1:0]        memOUT;

`ifdef MEM_ARB_LOCK_EN
   logic [Ncores-1:0]     coreLock;

   modport slave (
      input  coreLoad, coreWrite, coreADDR, coreIN, coreLock, memOUT,
      output coreOUT, coreAck, memADDR, memIN, memLoad, memWrite
   );

   modport master (
      output coreLoad, coreWrite, coreADDR, coreIN, coreLock, memOUT,
      input  coreOUT, coreAck, memADDR, memIN, memLoad, memWrite
   );
`else
   modport slave (
      input  coreLoad, coreWrite, coreADDR, coreIN, memOUT,
      output coreOUT, coreAck, memADDR, memIN, memLoad, memWrite
   );

   modport master (
      output coreLoad, coreWrite, coreADDR, coreIN, memOUT,
      input  coreOUT, coreAck, memADDR, memIN, memLoad, memWrite
   );
`endif

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first requester strictly after `last`, wrapping.
module rr_picker
   import mem_arb_pkg::*;
#(
   parameter int unsigned Ncores = 2,
   localparam int unsigned IdxW  = (Ncores > 1) ? $clog2(Ncores) : 1
) (
   input  logic [Ncores-1:0] req,
   input  logic [IdxW-1:0]   last,
   output logic [Ncores-1:0] grant,
   output logic [IdxW-1:0]   grantIdx,
   output logic              any
);

   always_comb begin : pick
      int unsigned idx;
      grant    = '0;
      grantIdx = '0;
      any      = 1'b0;
      idx      = 0;
      // Offset Ncores wraps back to `last` itself, so it is examined last.
      for (int unsigned off = 1; off <= Ncores; off++) begin
         idx = (32'(last) + off) % Ncores;
         if (!any && req[IdxW'(idx)]) begin
            any                 = 1'b1;
            grant[IdxW'(idx)]   = 1'b1;
            grantIdx            = IdxW'(idx);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sequencer sharing single-port DataMEM among Ncores cores, one access per 3 cycles.
// Define MEM_ARB_LOCK_EN to add coreLock, which pins arbitration to the locking core.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned Ncores = 2,
   parameter int unsigned TAM    = DefTAM,
   parameter int unsigned Lmem   = DefLmem
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   localparam int unsigned    IdxW     = (Ncores > 1) ? $clog2(Ncores) : 1;
   localparam logic [TAM-1:0] AddrMask = TAM'({Lmem{1'b1}});

   arbStateT                   state;
   arbCmdT                     cmd;
   logic [IdxW-1:0]            winner;
   logic [IdxW-1:0]            last;
   logic [Ncores-1:0]          winnerOh;
   logic [Ncores-1:0]          ack;
   logic [Ncores-1:0][TAM-1:0] coreOut;
   logic [TAM-1:0]             memAddr;
   logic [TAM-1:0]             memIn;
   logic                       memLoad;
   logic                       memWrite;

   logic [Ncores-1:0]          req;
   logic [Ncores-1:0]          pickReq;
   logic [Ncores-1:0]          grant;
   logic [IdxW-1:0]            grantIdx;
   logic                       any;

   assign req = bus.coreLoad | bus.coreWrite;

`ifdef MEM_ARB_LOCK_EN
   logic locked;
   // While locked only the previous winner may be granted; it is the core holding the lock.
   assign pickReq = locked ? (req & winnerOh) : req;
`else
   assign pickReq = req;
`endif

   rr_picker #(
      .Ncores(Ncores)
   ) picker (
      .req     (pickReq),
      .last    (last),
      .grant   (grant),
      .grantIdx(grantIdx),
      .any     (any)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cmd      <= CMD_LOAD;
         winner   <= '0;
         winnerOh <= '0;
         last     <= IdxW'(Ncores - 1);
         ack      <= '0;
         coreOut  <= '0;
         memAddr  <= '0;
         memIn    <= '0;
         memLoad  <= 1'b0;
         memWrite <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
         locked   <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (any) begin
                  winner   <= grantIdx;
                  winnerOh <= grant;
                  last     <= grantIdx;
                  // Write wins when a core raises both load and write.
                  cmd      <= bus.coreWrite[grantIdx] ? CMD_WRITE : CMD_LOAD;
                  memAddr  <= bus.coreADDR[grantIdx*TAM +: TAM] & AddrMask;
                  memIn    <= bus.coreIN[grantIdx*TAM +: TAM];
                  memLoad  <= !bus.coreWrite[grantIdx];
                  memWrite <= bus.coreWrite[grantIdx];
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               memLoad  <= 1'b0;
               memWrite <= 1'b0;
               ack      <= winnerOh;
               state    <= RESP;
            end
            RESP: begin
               ack <= '0;
               if (cmd == CMD_LOAD) begin
                  coreOut[winner] <= bus.memOUT;
               end
`ifdef MEM_ARB_LOCK_EN
               locked <= bus.coreLock[winner];
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.coreOUT  = coreOut;
   assign bus.coreAck  = ack;
   assign bus.memADDR  = memAddr;
   assign bus.memIN    = memIn;
   assign bus.memLoad  = memLoad;
   assign bus.memWrite = memWrite;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (4 cores): transaction-level round-robin model plus
// shadow memory; MEM_ARB_LOCK_EN enables the locked read-modify-write scenario.
module tb_mem_arbiter;

   localparam int N   = 4;
   localparam int TAM = 16;

   logic clk     = 1'b0;
   logic rst     = 1'b0;
   logic fillMem = 1'b1;

   always #5 clk = ~clk;

   mem_arbiter_if #(.Ncores(N), .TAM(TAM)) bus ();

   mem_arbiter #(
      .Ncores(N),
      .TAM   (TAM),
      .Lmem  (8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // DataMEM model: write on the strobe-ending edge, read data one cycle after memLoad.
   logic [15:0] memArr [256];

   function automatic logic [15:0] memSeed(int i);
      return 16'(i * 40503 + 4660);
   endfunction

   always @(posedge clk) begin
      if (fillMem) begin
         for (int i = 0; i < 256; i++) memArr[i] <= memSeed(i);
      end else if (bus.memWrite) begin
         memArr[bus.memADDR[7:0]] <= bus.memIN;
      end
      if (bus.memLoad) bus.memOUT <= memArr[bus.memADDR[7:0]];
   end

   int tests  = 0;
   int failed = 0;

   int          cyc        = 0;
   int          expectAt   = -1;
   int          lastAckCyc = -100;
   int          lastM      = N - 1;
   int          ackTotal   = 0;
   int          ackCnt     [N];
   bit          pending    [N];
   bit          opWrite    [N];
   bit          opBoth     [N];
   logic [15:0] opAddr     [N];
   logic [15:0] opData     [N];
   logic [15:0] expOut     [N];
   logic [15:0] shadow     [256];
   bit          lockDrv    [N];
   bit          lockActive = 1'b0;
   int          lockCore   = 0;
   int          lockUpd    = -1;
   bit          randomMode = 1'b0;
   int          reraisePct = 0;
   logic        prevLoad   = 1'b0;
   logic        prevWrite  = 1'b0;
   logic [15:0] prevAddr   = '0;
   logic [15:0] prevIn     = '0;
   int          ackLogCore [$];
   int          ackLogCyc  [$];

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit anyPending();
      for (int i = 0; i < N; i++) if (pending[i]) return 1'b1;
      return 1'b0;
   endfunction

   // Next core to be served: the lock holder, else first pending index after lastM.
   function automatic int predict();
      if (lockActive) return pending[lockCore] ? lockCore : -1;
      for (int k = 1; k <= N; k++) begin
         int c = (lastM + k) % N;
         if (pending[c]) return c;
      end
      return -1;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         bus.coreLoad[i]            = pending[i] && (!opWrite[i] || opBoth[i]);
         bus.coreWrite[i]           = pending[i] && opWrite[i];
         bus.coreADDR[i*TAM +: TAM] = opAddr[i];
         bus.coreIN[i*TAM +: TAM]   = opData[i];
`ifdef MEM_ARB_LOCK_EN
         bus.coreLock[i]            = lockDrv[i];
`endif
      end
   endtask

   // kind: 0 load, 1 write, 2 load+write (write must win)
   task automatic raise(int c, int kind, logic [15:0] a, logic [15:0] d);
      pending[c] = 1'b1;
      opWrite[c] = (kind != 0);
      opBoth[c]  = (kind == 2);
      opAddr[c]  = a;
      opData[c]  = d;
      drive();
      if (expectAt < 0) expectAt = (lastAckCyc == cyc) ? cyc + 3 : cyc + 2;
   endtask

   task automatic raiseRandom(int c);
      raise(c, int'($urandom_range(2)), {8'($urandom), 4'h0, 4'($urandom_range(15))},
            16'($urandom));
   endtask

   task automatic handleAck();
      int w;
      w = predict();
      if (w < 0) begin
         check("spuriousAck", bus.coreAck, 0);
         return;
      end
      check("ackOneHot", bus.coreAck, 64'(1) << w);
      check("ackCycle", 64'(cyc), 64'(expectAt));
      check("strobeKind", {prevLoad, prevWrite}, opWrite[w] ? 2'b01 : 2'b10);
      check("memADDR", prevAddr, opAddr[w] & 16'h00FF);
      if (opWrite[w]) begin
         check("memIN", prevIn, opData[w]);
         shadow[opAddr[w][7:0]] = opData[w];
      end else begin
         expOut[w] = shadow[opAddr[w][7:0]];
      end
      lastM = w;
      pending[w] = 1'b0;
      ackCnt[w]++;
      ackTotal++;
      ackLogCore.push_back(w);
      ackLogCyc.push_back(cyc);
      lastAckCyc = cyc;
      lockUpd    = w;
      expectAt   = -1;
      if (randomMode) begin
         for (int i = 0; i < N; i++)
            if (!pending[i] && int'($urandom_range(99)) < reraisePct) raiseRandom(i);
      end
      expectAt = anyPending() ? cyc + 3 : -1;
      drive();
   endtask

   task automatic step();
      logic [63:0] e;
      @(posedge clk);
      cyc++;
      // Lock is sampled by the DUT at the edge that ends the ack cycle.
      if (lockUpd >= 0) begin
         lockActive = lockDrv[lockUpd];
         lockCore   = lockUpd;
         lockUpd    = -1;
      end
      @(negedge clk);
      for (int i = 0; i < N; i++) e[i*TAM +: TAM] = expOut[i];
      check("coreOUT", bus.coreOUT, e);
      check("strobe", bus.memLoad | bus.memWrite, cyc == expectAt - 1);
      check("strobeExcl", bus.memLoad & bus.memWrite, 0);
      if (bus.coreAck != '0 || (expectAt >= 0 && cyc == expectAt)) handleAck();
      prevLoad  = bus.memLoad;
      prevWrite = bus.memWrite;
      prevAddr  = bus.memADDR;
      prevIn    = bus.memIN;
   endtask

   task automatic runAcks(int k);
      int target = ackTotal + k;
      int budget = 3 * k * N + 10;
      while (ackTotal < target && budget > 0) begin
         step();
         budget--;
      end
      if (ackTotal < target) check("ackBudget", 64'(ackTotal), 64'(target));
   endtask

   task automatic drain();
      int budget = 3 * N + 10;
      while ((anyPending() || expectAt >= 0) && budget > 0) begin
         step();
         budget--;
      end
      if (anyPending()) check("drain", bus.coreAck, 64'(1) << predict());
   endtask

   task automatic modelReset();
      for (int i = 0; i < N; i++) begin
         pending[i] = 1'b0;
         expOut[i]  = '0;
      end
      lastM      = N - 1;
      expectAt   = -1;
      lastAckCyc = -100;
      lockActive = 1'b0;
      lockUpd    = -1;
      prevLoad   = 1'b0;
      prevWrite  = 1'b0;
      drive();
   endtask

   initial begin
      int base [N];
      int s;
      for (int i = 0; i < 256; i++) shadow[i] = memSeed(i);
      for (int i = 0; i < N; i++) begin
         ackCnt[i]  = 0;
         opWrite[i] = 1'b0;
         opBoth[i]  = 1'b0;
         opAddr[i]  = '0;
         opData[i]  = '0;
         lockDrv[i] = 1'b0;
      end
      modelReset();
      @(negedge clk);
      fillMem = 1'b0;

      // Reset state
      check("rstMemLoad", bus.memLoad, 0);
      check("rstMemWrite", bus.memWrite, 0);
      check("rstCoreAck", bus.coreAck, 0);
      check("rstCoreOUT", bus.coreOUT, 0);
      check("rstMemADDR", bus.memADDR, 0);
      check("rstMemIN", bus.memIN, 0);
      rst = 1'b1;

      // Two cores load right at reset release: core0 first, then core1
      s = cyc;
      raise(0, 0, 16'h0040, 16'h0);
      raise(1, 0, 16'h0041, 16'h0);
      runAcks(2);
      check("simFirstCore", 64'(ackLogCore[0]), 0);
      check("simFirstCyc", 64'(ackLogCyc[0]), 64'(s + 2));
      check("simSecondCore", 64'(ackLogCore[1]), 1);
      check("simSecondCyc", 64'(ackLogCyc[1]), 64'(s + 5));

      // Single write then load of the same address
      base[1] = ackCnt[1];
      raise(0, 1, 16'h0012, 16'hBEEF);
      runAcks(1);
      raise(0, 0, 16'h0012, 16'h0);
      runAcks(1);
      step();
      check("wrRdData", bus.coreOUT[15:0], 16'hBEEF);
      check("wrRdNoAck1", 64'(ackCnt[1] - base[1]), 0);

      // Load+write together on core1: write only, coreOUT[1] untouched
      raise(1, 2, 16'h0005, 16'h1234);
      runAcks(1);
      step();
      check("bothOut1", bus.coreOUT[31:16], 16'hAAAA & 16'h0000 | shadow[16'h0041 & 16'hFF]);
      raise(1, 0, 16'h0005, 16'h0);
      runAcks(1);
      step();
      check("bothWritten", bus.coreOUT[31:16], 16'h1234);

      // Continuous contention on all four cores
      for (int i = 0; i < N; i++) base[i] = ackCnt[i];
      randomMode = 1'b1;
      reraisePct = 100;
      for (int i = 0; i < N; i++) raiseRandom(i);
      runAcks(12);
      randomMode = 1'b0;
      for (int i = 0; i < N; i++)
         check($sformatf("fairCore%0d", i), 64'(ackCnt[i] - base[i]), 3);
      drain();

      // Reset in the middle of an ISSUE cycle
      raise(2, 1, 16'h0077, shadow[8'h77]);
      for (int k = 0; k < 4 && !(bus.memLoad | bus.memWrite); k++) step();
      #2 rst = 1'b0;
      #1;
      check("midRstStrobe", {bus.memLoad, bus.memWrite}, 0);
      check("midRstAck", bus.coreAck, 0);
      modelReset();
      @(negedge clk);
      rst = 1'b1;
      ackLogCore.delete();
      ackLogCyc.delete();
      for (int i = 0; i < N; i++) raise(i, 0, 16'(8'h60 + i), 16'h0);
      runAcks(N);
      check("postRstFirst", 64'(ackLogCore[0]), 0);

      // Randomised traffic
      randomMode = 1'b1;
      reraisePct = 50;
      for (int k = 0; k < 400; k++) begin
         step();
         if (!anyPending() && expectAt < 0 && $urandom_range(3) == 0) begin
            raiseRandom(int'($urandom_range(N - 1)));
            for (int i = 0; i < N; i++) if (!pending[i] && $urandom_range(1) == 1) raiseRandom(i);
         end
      end
      randomMode = 1'b0;
      drain();

`ifdef MEM_ARB_LOCK_EN
      // Locked read-modify-write by core1 while core0 waits
      raise(0, 0, 16'h0031, 16'h0);
      drain();
      ackLogCore.delete();
      lockDrv[1] = 1'b1;
      raise(1, 0, 16'h0020, 16'h0);
      raise(0, 0, 16'h0030, 16'h0);
      runAcks(1);
      raise(1, 1, 16'h0020, expOut[1] + 16'h1);
      step();
      lockDrv[1] = 1'b0;
      drive();
      runAcks(2);
      check("lockFirst", 64'(ackLogCore[0]), 1);
      check("lockSecond", 64'(ackLogCore[1]), 1);
      check("lockThird", 64'(ackLogCore[2]), 0);
      drain();
`endif

      step();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
